// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity mode constants and the parity helper.
// Used by both the TX and RX blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CLEANUP,
        S_BREAK,
        S_BREAK_MARK
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // The word is zero-extended to 9 bits, which leaves its XOR reduction unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Word handshake and line outputs of the UART transmitter.
// The system side uses the master modport and the transmitter uses the slave modport.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 i_Tx_Dv;
    logic [DATA_BITS-1:0] i_Tx_Byte;
    logic                 o_Tx_Ready;
    logic                 o_Tx_Active;
    logic                 o_Tx_Done;
    logic                 o_Tx_Serial;

    modport master (
        output i_Tx_Dv, i_Tx_Byte,
        input  o_Tx_Ready, o_Tx_Active, o_Tx_Done, o_Tx_Serial
    );

    modport slave (
        input  i_Tx_Dv, i_Tx_Byte,
        output o_Tx_Ready, o_Tx_Active, o_Tx_Done, o_Tx_Serial
    );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter. It ticks on the last cycle of every period and is held at zero while clear is high.
module uart_baud_cnt #(
    parameter int CLK_CY_PER_BIT = 87
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);
    localparam int            CW   = $clog2(CLK_CY_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLK_CY_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_clr || (cnt_q == LAST)) cnt_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign o_tick = (cnt_q == LAST) && !i_clr;
endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable data width, parity, stop bits and bit period.
// Optional line-break support is enabled by defining UART_TX_BREAK_EN.
//
// state        | meaning
// S_IDLE       | line mark, ready to accept a word
// S_START      | start bit (line 0)
// S_DATA       | data bits, LSB first
// S_PARITY     | parity bit (only when PARITY != none)
// S_STOP       | stop bit(s), line 1
// S_CLEANUP    | one cycle with Done high, not ready
// S_BREAK      | line held 0 while break is requested
// S_BREAK_MARK | one mark period after break release
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_CY_PER_BIT = 87,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
`ifdef UART_TX_BREAK_EN
    input  logic        i_Tx_Break,
`endif
    uart_tx_cfg_if.slave tx
);
    if (CLK_CY_PER_BIT < 2) begin : g_err_cyc
        $error("uart_tx_cfg: CLK_CY_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_db
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_err_par
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam int            IW       = $clog2(DATA_BITS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [IW-1:0]        idx_q;
    logic                 stop_q;
    logic                 par_q;
    logic                 serial_q;
    logic                 active_q;
    logic                 done_q;
    logic                 tick;
    logic                 clr;
    logic                 brk;

`ifdef UART_TX_BREAK_EN
    assign brk = i_Tx_Break;
`else
    assign brk = 1'b0;
`endif

    // The period counter only runs in states whose length is measured in bit periods.
    assign clr = (state_q == S_IDLE) || (state_q == S_CLEANUP) || (state_q == S_BREAK);

    uart_baud_cnt #(.CLK_CY_PER_BIT(CLK_CY_PER_BIT)) u_baud (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (clr),
        .o_tick  (tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    serial_q <= 1'b1;
                    if (brk) begin
                        serial_q <= 1'b0;
                        state_q  <= S_BREAK;
                    end else if (tx.i_Tx_Dv) begin
                        shift_q  <= tx.i_Tx_Byte;
                        par_q    <= parity_bit(9'(tx.i_Tx_Byte), PARITY);
                        idx_q    <= '0;
                        stop_q   <= 1'b0;
                        active_q <= 1'b1;
                        serial_q <= 1'b0;
                        state_q  <= S_START;
                    end
                end
                S_START: if (tick) begin
                    serial_q <= shift_q[0];
                    state_q  <= S_DATA;
                end
                S_DATA: if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        if (PARITY != PARITY_NONE) begin
                            serial_q <= par_q;
                            state_q  <= S_PARITY;
                        end else begin
                            serial_q <= 1'b1;
                            state_q  <= S_STOP;
                        end
                    end else begin
                        idx_q    <= idx_q + 1'b1;
                        shift_q  <= shift_q >> 1;
                        serial_q <= shift_q[1];
                    end
                end
                S_PARITY: if (tick) begin
                    serial_q <= 1'b1;
                    state_q  <= S_STOP;
                end
                S_STOP: if (tick) begin
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_CLEANUP;
                    end else begin
                        stop_q <= 1'b1;
                    end
                end
                S_CLEANUP: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_BREAK: if (!brk) begin
                    serial_q <= 1'b1;
                    state_q  <= S_BREAK_MARK;
                end
                S_BREAK_MARK: if (tick) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx.o_Tx_Ready  = (state_q == S_IDLE) && !brk;
    assign tx.o_Tx_Active = active_q;
    assign tx.o_Tx_Done   = done_q;
    assign tx.o_Tx_Serial = serial_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg covering 8N1, 7E2 and 8O1 frames, back-to-back sends and reset mid-frame.
// When UART_TX_BREAK_EN is defined it also covers line break.
module tb_uart_tx_cfg;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    uart_tx_cfg_if #(.DATA_BITS(8)) ifa ();
    uart_tx_cfg_if #(.DATA_BITS(7)) ifb ();
    uart_tx_cfg_if #(.DATA_BITS(8)) ifc ();

`ifdef UART_TX_BREAK_EN
    logic brk;
`endif

    uart_tx_cfg #(.CLK_CY_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
`ifdef UART_TX_BREAK_EN
        .i_Tx_Break (brk),
`endif
        .tx      (ifa)
    );

    uart_tx_cfg #(.CLK_CY_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
`ifdef UART_TX_BREAK_EN
        .i_Tx_Break (1'b0),
`endif
        .tx      (ifb)
    );

    uart_tx_cfg #(.CLK_CY_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_c (
        .i_clk   (clk),
        .i_rst_n (rst_n),
`ifdef UART_TX_BREAK_EN
        .i_Tx_Break (1'b0),
`endif
        .tx      (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit list (bit t = t-th bit on the line) stretched to 4 cycles per bit, followed by 2 mark cycles.
    function automatic logic [63:0] expand(input logic [15:0] bits, input int nb);
        logic [63:0] r;
        r = '0;
        for (int t = 0; t < nb * 4 + 2; t++) r[t] = (t < nb * 4) ? bits[t / 4] : 1'b1;
        return r;
    endfunction

    // Called on the negedge of frame cycle 0; samples n + 2 cycles, one per negedge.
    task automatic cap(input int sel, input int n, output logic [63:0] ln,
                       output int ndone, output int dpos, output int nact);
        logic s, d, a;
        ln = '0; ndone = 0; dpos = -1; nact = 0;
        for (int k = 0; k < n + 2; k++) begin
            case (sel)
                1:       begin s = ifb.o_Tx_Serial; d = ifb.o_Tx_Done; a = ifb.o_Tx_Active; end
                2:       begin s = ifc.o_Tx_Serial; d = ifc.o_Tx_Done; a = ifc.o_Tx_Active; end
                default: begin s = ifa.o_Tx_Serial; d = ifa.o_Tx_Done; a = ifa.o_Tx_Active; end
            endcase
            ln[k] = s;
            if (d) begin ndone++; dpos = k; end
            if (k < n && a) nact++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [63:0] ln;
        int nd, dp, na;
        checks = 0; errors = 0;
        rst_n = 1'b0;
        ifa.i_Tx_Dv = 1'b0; ifa.i_Tx_Byte = '0;
        ifb.i_Tx_Dv = 1'b0; ifb.i_Tx_Byte = '0;
        ifc.i_Tx_Dv = 1'b0; ifc.i_Tx_Byte = '0;
`ifdef UART_TX_BREAK_EN
        brk = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_serial", 64'(ifa.o_Tx_Serial), 64'd1);
        chk("rst_active", 64'(ifa.o_Tx_Active), 64'd0);
        chk("rst_done",   64'(ifa.o_Tx_Done),   64'd0);
        chk("rst_ready",  64'(ifa.o_Tx_Ready),  64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 0xA5
        ifa.i_Tx_Byte = 8'hA5; ifa.i_Tx_Dv = 1'b1;
        @(negedge clk);
        ifa.i_Tx_Dv = 1'b0;
        chk("a5_ready_busy", 64'(ifa.o_Tx_Ready), 64'd0);
        cap(0, 40, ln, nd, dp, na);
        chk("a5_line",  ln, expand(16'b11_0100_1010, 10));
        chk("a5_ndone", 64'(nd), 64'd1);
        chk("a5_dpos",  64'(dp), 64'd40);
        chk("a5_act",   64'(na), 64'd40);

        // 7E2 0x41
        ifb.i_Tx_Byte = 7'h41; ifb.i_Tx_Dv = 1'b1;
        @(negedge clk);
        ifb.i_Tx_Dv = 1'b0;
        cap(1, 44, ln, nd, dp, na);
        chk("41_line",  ln, expand(16'b110_1000_0010, 11));
        chk("41_ndone", 64'(nd), 64'd1);
        chk("41_dpos",  64'(dp), 64'd44);
        chk("41_act",   64'(na), 64'd44);

        // 8O1 0xFF, 0x00, 0x01
        ifc.i_Tx_Byte = 8'hFF; ifc.i_Tx_Dv = 1'b1;
        @(negedge clk);
        ifc.i_Tx_Dv = 1'b0;
        cap(2, 44, ln, nd, dp, na);
        chk("ff_line", ln, expand(16'b111_1111_1110, 11));
        chk("ff_dpos", 64'(dp), 64'd44);
        ifc.i_Tx_Byte = 8'h00; ifc.i_Tx_Dv = 1'b1;
        @(negedge clk);
        ifc.i_Tx_Dv = 1'b0;
        cap(2, 44, ln, nd, dp, na);
        chk("00_line", ln, expand(16'b110_0000_0000, 11));
        ifc.i_Tx_Byte = 8'h01; ifc.i_Tx_Dv = 1'b1;
        @(negedge clk);
        ifc.i_Tx_Dv = 1'b0;
        cap(2, 44, ln, nd, dp, na);
        chk("01_line", ln, expand(16'b100_0000_0010, 11));

        // Dv held high: 0x55 then 0x0F back-to-back; the byte change mid-frame must not leak in
        ifa.i_Tx_Byte = 8'h55; ifa.i_Tx_Dv = 1'b1;
        @(negedge clk);
        ifa.i_Tx_Byte = 8'h0F;
        cap(0, 40, ln, nd, dp, na);
        chk("b2b_55_line", ln, expand(16'b10_1010_1010, 10));
        chk("b2b_55_dpos", 64'(dp), 64'd40);
        ifa.i_Tx_Dv = 1'b0;
        cap(0, 40, ln, nd, dp, na);
        chk("b2b_0f_line", ln, expand(16'b10_0001_1110, 10));
        chk("b2b_0f_ndone", 64'(nd), 64'd1);

        // Reset during data bit 3 (cycles 16..19) of 0xA5
        ifa.i_Tx_Byte = 8'hA5; ifa.i_Tx_Dv = 1'b1;
        @(negedge clk);
        ifa.i_Tx_Dv = 1'b0;
        repeat (17) @(negedge clk);
        chk("prerst_line", 64'(ifa.o_Tx_Serial), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_serial", 64'(ifa.o_Tx_Serial), 64'd1);
        chk("midrst_active", 64'(ifa.o_Tx_Active), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_done", 64'(ifa.o_Tx_Done), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_ready", 64'(ifa.o_Tx_Ready), 64'd1);
        ifa.i_Tx_Byte = 8'h3C; ifa.i_Tx_Dv = 1'b1;
        @(negedge clk);
        ifa.i_Tx_Dv = 1'b0;
        cap(0, 40, ln, nd, dp, na);
        chk("3c_line", ln, expand(16'b10_0111_1000, 10));
        chk("3c_ndone", 64'(nd), 64'd1);

`ifdef UART_TX_BREAK_EN
        // Break for 20 cycles with Dv asserted on the same cycle: break wins
        brk = 1'b1; ifa.i_Tx_Byte = 8'h00; ifa.i_Tx_Dv = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("brk_line",   64'(ifa.o_Tx_Serial), 64'd0);
            chk("brk_ready",  64'(ifa.o_Tx_Ready),  64'd0);
            chk("brk_active", 64'(ifa.o_Tx_Active), 64'd0);
        end
        brk = 1'b0; ifa.i_Tx_Dv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("brk_mark_line",  64'(ifa.o_Tx_Serial), 64'd1);
            chk("brk_mark_ready", 64'(ifa.o_Tx_Ready),  64'd0);
        end
        @(negedge clk);
        chk("brk_ready_back", 64'(ifa.o_Tx_Ready), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
